// File: rtl/ulpi_pkg.sv
// Shared ULPI receive-side types: RxEvent encoding, rx_cmd field offsets, framer states.
// Used by ulpi_rx_framer; the optional ULPI_RX_STATS_EN build adds no package content.
package ulpi_pkg;

  typedef enum logic [1:0] {
    RX_INACTIVE = 2'b00,
    RX_ACTIVE   = 2'b01,
    RX_HOSTDISC = 2'b10,
    RX_ERROR    = 2'b11
  } rx_event_e;

  localparam int unsigned LS_OFF   = 0;
  localparam int unsigned VBUS_OFF = 2;
  localparam int unsigned EVT_OFF  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } framer_state_e;

  function automatic rx_event_e rx_event(input logic [7:0] cmd);
    return rx_event_e'(cmd[EVT_OFF +: 2]);
  endfunction

endpackage

// File: rtl/ulpi_rx_framer_if.sv
// Receive-side bundle between the ULPI link outputs and the packet framer.
// stat_pkts/stat_errs exist only when ULPI_RX_STATS_EN is defined.
interface ulpi_rx_framer_if #(
  parameter int LEN_W = 11
);
  logic [7:0]       rx_cmd;
  logic [7:0]       data;
  logic             data_valid;
  logic [7:0]       pkt_data;
  logic             pkt_valid;
  logic             pkt_sop;
  logic             pkt_eop;
  logic             pkt_err;
  logic [LEN_W-1:0] pkt_len;
  logic [1:0]       line_state;
  logic [1:0]       vbus_state;
  logic             host_disc;
`ifdef ULPI_RX_STATS_EN
  logic [15:0]      stat_pkts;
  logic [15:0]      stat_errs;
`endif

  modport slave (
    input  rx_cmd, data, data_valid,
    output pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_err, pkt_len,
    output line_state, vbus_state, host_disc
`ifdef ULPI_RX_STATS_EN
    , output stat_pkts, stat_errs
`endif
  );

  modport master (
    output rx_cmd, data, data_valid,
    input  pkt_data, pkt_valid, pkt_sop, pkt_eop, pkt_err, pkt_len,
    input  line_state, vbus_state, host_disc
`ifdef ULPI_RX_STATS_EN
    , input stat_pkts, stat_errs
`endif
  );

endinterface

// File: rtl/ulpi_rx_stats.sv
// Saturating packet / errored-packet counters, instantiated under ULPI_RX_STATS_EN.
module ulpi_rx_stats (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        eop_i,
  input  logic        err_i,
  output logic [15:0] stat_pkts_o,
  output logic [15:0] stat_errs_o
);

  logic [15:0] pkts_q, pkts_d;
  logic [15:0] errs_q, errs_d;

  always_comb begin
    pkts_d = pkts_q;
    errs_d = errs_q;
    if (eop_i && (pkts_q != '1)) pkts_d = pkts_q + 16'd1;
    if (eop_i && err_i && (errs_q != '1)) errs_d = errs_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkts_q <= '0;
      errs_q <= '0;
    end else begin
      pkts_q <= pkts_d;
      errs_q <= errs_d;
    end
  end

  assign stat_pkts_o = pkts_q;
  assign stat_errs_o = errs_q;

endmodule

// File: rtl/ulpi_rx_framer.sv
// Frames ULPI receive bytes into sop/eop-marked packets and registers RX CMD status.
// Define ULPI_RX_STATS_EN to add the stat_pkts/stat_errs counters.
module ulpi_rx_framer
  import ulpi_pkg::*;
#(
  parameter int MAX_LEN = 1027,
  parameter int LEN_W   = 11
) (
  input logic              clk,
  input logic              reset_n,
  ulpi_rx_framer_if.slave  rx
);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  framer_state_e    state_q, state_d;
  logic             active_q;
  logic [7:0]       hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic             first_q, first_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;

  logic [7:0]       pkt_data_q, pkt_data_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             pkt_sop_q, pkt_sop_d;
  logic             pkt_eop_q, pkt_eop_d;
  logic             pkt_err_q, pkt_err_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;

  logic [1:0]       line_state_q, vbus_state_q;
  logic             host_disc_q;

  rx_event_e evt;
  logic      active, rise, fall, at_max, accept, err_now;
  logic      unused_cmd_bits;

  assign evt     = rx_event(rx.rx_cmd);
  assign active  = rx.rx_cmd[EVT_OFF];
  assign rise    = active & ~active_q;
  assign fall    = ~active & active_q;
  assign at_max  = (len_q == MAX_LEN_V);
  assign accept  = rx.data_valid & ~at_max;
  assign unused_cmd_bits = &{1'b0, rx.rx_cmd[7:6]};

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    first_d     = first_q;
    len_d       = len_q;
    err_d       = err_q;
    pkt_valid_d = 1'b0;
    pkt_data_d  = pkt_data_q;
    pkt_sop_d   = pkt_sop_q;
    pkt_eop_d   = pkt_eop_q;
    pkt_err_d   = pkt_err_q;
    pkt_len_d   = pkt_len_q;
    err_now     = err_q | (evt == RX_ERROR) | (rx.data_valid & at_max);

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = ACTIVE;
          len_d    = '0;
          err_d    = 1'b0;
          first_d  = 1'b1;
          hold_v_d = 1'b0;
        end
      end

      ACTIVE: begin
        err_d = err_now;
        if (accept) begin
          if (hold_v_q) begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = hold_q;
            pkt_sop_d   = first_q;
            pkt_eop_d   = 1'b0;
            first_d     = 1'b0;
          end
          hold_d   = rx.data;
          hold_v_d = 1'b1;
          len_d    = len_q + LEN_W'(1);
        end
        if (fall) begin
          // A byte accepted on the falling edge becomes the eop byte, emitted from DRAIN
          if (accept) begin
            state_d = DRAIN;
          end else begin
            if (hold_v_q) begin
              pkt_valid_d = 1'b1;
              pkt_data_d  = hold_q;
              pkt_sop_d   = first_q;
              pkt_eop_d   = 1'b1;
              pkt_err_d   = err_now;
              pkt_len_d   = len_q;
              first_d     = 1'b0;
            end
            hold_v_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end

      DRAIN: begin
        pkt_valid_d = 1'b1;
        pkt_data_d  = hold_q;
        pkt_sop_d   = first_q;
        pkt_eop_d   = 1'b1;
        pkt_err_d   = err_q;
        pkt_len_d   = len_q;
        hold_v_d    = 1'b0;
        first_d     = 1'b0;
        state_d     = IDLE;
        // Emission above uses the old context; a new packet may start right now
        if (rise) begin
          state_d = ACTIVE;
          len_d   = '0;
          err_d   = 1'b0;
          first_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      active_q     <= 1'b0;
      hold_q       <= '0;
      hold_v_q     <= 1'b0;
      first_q      <= 1'b0;
      len_q        <= '0;
      err_q        <= 1'b0;
      pkt_data_q   <= '0;
      pkt_valid_q  <= 1'b0;
      pkt_sop_q    <= 1'b0;
      pkt_eop_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
      pkt_len_q    <= '0;
      line_state_q <= '0;
      vbus_state_q <= '0;
      host_disc_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active;
      hold_q       <= hold_d;
      hold_v_q     <= hold_v_d;
      first_q      <= first_d;
      len_q        <= len_d;
      err_q        <= err_d;
      pkt_data_q   <= pkt_data_d;
      pkt_valid_q  <= pkt_valid_d;
      pkt_sop_q    <= pkt_sop_d;
      pkt_eop_q    <= pkt_eop_d;
      pkt_err_q    <= pkt_err_d;
      pkt_len_q    <= pkt_len_d;
      line_state_q <= rx.rx_cmd[LS_OFF +: 2];
      vbus_state_q <= rx.rx_cmd[VBUS_OFF +: 2];
      host_disc_q  <= (evt == RX_HOSTDISC);
    end
  end

  assign rx.pkt_data   = pkt_data_q;
  assign rx.pkt_valid  = pkt_valid_q;
  assign rx.pkt_sop    = pkt_sop_q;
  assign rx.pkt_eop    = pkt_eop_q;
  assign rx.pkt_err    = pkt_err_q;
  assign rx.pkt_len    = pkt_len_q;
  assign rx.line_state = line_state_q;
  assign rx.vbus_state = vbus_state_q;
  assign rx.host_disc  = host_disc_q;

`ifdef ULPI_RX_STATS_EN
  ulpi_rx_stats u_stats (
    .clk         (clk),
    .reset_n     (reset_n),
    .eop_i       (pkt_valid_d & pkt_eop_d),
    .err_i       (pkt_err_d),
    .stat_pkts_o (rx.stat_pkts),
    .stat_errs_o (rx.stat_errs)
  );
`endif

endmodule

// File: tb/tb_ulpi_rx_framer.sv
// Directed scoreboard bench for ulpi_rx_framer; stats checks compile under ULPI_RX_STATS_EN.
module tb_ulpi_rx_framer;

  localparam int MAX_LEN = 1027;
  localparam int LEN_W   = 11;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]       d;
    logic             sop;
    logic             eop;
    logic             err;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;
  int   pushed = 0;
  int   exp_pkts = 0;
  int   exp_errs = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ulpi_rx_framer_if #(.LEN_W(LEN_W)) ifc ();

  ulpi_rx_framer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (ifc.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pushes the expected emissions, then drives the packet on the link side.
  task automatic send_pkt(input bq_t b, input int err_at, input bit simul, input bit chain);
    int n;
    int en;
    bit e;
    exp_t x;
    n  = b.size();
    en = (n > MAX_LEN) ? MAX_LEN : n;
    e  = (err_at >= 0) || (n > MAX_LEN);
    for (int i = 0; i < en; i++) begin
      x.d   = b[i];
      x.sop = (i == 0);
      x.eop = (i == en - 1);
      x.err = e;
      x.len = LEN_W'(en);
      sb.push_back(x);
      pushed++;
    end
    exp_pkts++;
    if (e) exp_errs++;
    ifc.rx_cmd = 8'h10;
    step(1);
    for (int i = 0; i < n; i++) begin
      if (err_at >= 0 && i >= err_at) ifc.rx_cmd = 8'h30;
      if (simul && i == n - 1) ifc.rx_cmd = 8'h00;
      ifc.data = b[i];
      ifc.data_valid = 1'b1;
      step(1);
    end
    ifc.data_valid = 1'b0;
    ifc.data = 8'h00;
    if (!simul) begin
      ifc.rx_cmd = 8'h00;
      step(1);
    end
    if (!chain) step(4);
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_pkt_valid"},  ifc.pkt_valid, 0);
    chk({pfx, "_pkt_data"},   ifc.pkt_data, 0);
    chk({pfx, "_pkt_sop"},    ifc.pkt_sop, 0);
    chk({pfx, "_pkt_eop"},    ifc.pkt_eop, 0);
    chk({pfx, "_pkt_err"},    ifc.pkt_err, 0);
    chk({pfx, "_pkt_len"},    ifc.pkt_len, 0);
    chk({pfx, "_line_state"}, ifc.line_state, 0);
    chk({pfx, "_vbus_state"}, ifc.vbus_state, 0);
    chk({pfx, "_host_disc"},  ifc.host_disc, 0);
`ifdef ULPI_RX_STATS_EN
    chk({pfx, "_stat_pkts"},  ifc.stat_pkts, 0);
    chk({pfx, "_stat_errs"},  ifc.stat_errs, 0);
`endif
  endtask

  always @(negedge clk) begin
    if (reset_n && ifc.pkt_valid) begin
      exp_t x;
      pulses++;
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_pulse observed=%0h expected=none", ifc.pkt_data);
      end
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("pkt_data", ifc.pkt_data, x.d);
        chk("pkt_sop",  ifc.pkt_sop,  x.sop);
        chk("pkt_eop",  ifc.pkt_eop,  x.eop);
        if (x.eop) begin
          chk("pkt_err", ifc.pkt_err, x.err);
          chk("pkt_len", ifc.pkt_len, x.len);
        end
      end
    end
  end

  initial begin
    bq_t b;
    ifc.rx_cmd = 8'h00;
    ifc.data = 8'h00;
    ifc.data_valid = 1'b0;

    step(2);
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    step(2);

    b = '{8'hA5, 8'hC3, 8'h0F};
    send_pkt(b, -1, 1'b0, 1'b0);

    b = '{8'h69};
    send_pkt(b, -1, 1'b0, 1'b0);

    b = '{8'h11, 8'h22, 8'h33};
    send_pkt(b, 2, 1'b0, 1'b0);

    // Falling edge with the last byte; next packet starts while DRAIN emits
    b = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    send_pkt(b, -1, 1'b1, 1'b1);
    b = '{8'hE1, 8'hE2};
    send_pkt(b, -1, 1'b0, 1'b0);

    b = {};
    for (int i = 0; i < 1030; i++) b.push_back(8'(i * 7 + 3));
    send_pkt(b, -1, 1'b0, 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
    chk("sb_drained", sb.size(), 0);
    chk("pulse_count", pulses, pushed);
`ifdef ULPI_RX_STATS_EN
    chk("stat_pkts", ifc.stat_pkts, exp_pkts);
    chk("stat_errs", ifc.stat_errs, exp_errs);
`endif

    // Reset in the middle of a packet: partial packet is discarded
    ifc.rx_cmd = 8'h10;
    step(1);
    ifc.data = 8'h44;
    ifc.data_valid = 1'b1;
    step(1);
    ifc.data = 8'h55;
    step(1);
    ifc.data_valid = 1'b0;
    reset_n = 1'b0;
    ifc.rx_cmd = 8'h23;
    step(2);
    chk_outputs_zero("midrst");
    reset_n = 1'b1;
    step(1);
    chk("ls_after_rst",   ifc.line_state, 2'd3);
    chk("vbus_after_rst", ifc.vbus_state, 2'd0);
    chk("hd_after_rst",   ifc.host_disc, 1'b1);
    step(5);

    ifc.rx_cmd = 8'h0D;
    chk("ls_latency", ifc.line_state, 2'd3);
    step(1);
    chk("ls_0d",   ifc.line_state, 2'd1);
    chk("vbus_0d", ifc.vbus_state, 2'd3);
    chk("hd_0d",   ifc.host_disc, 1'b0);
    step(3);

    chk("pulse_count_final", pulses, pushed);
    chk("sb_empty_final", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
